// File: rtl/lenet_pkg.sv
// Shared state encoding and digit constants for the LeNet run controller.
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

endpackage

// File: rtl/lenet_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the value the count
// will take this cycle and whether that value hits the terminal count.
module lenet_sat_counter #(
  parameter int unsigned LAT_W = 20,
  parameter int unsigned TERM  = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [LAT_W-1:0] o_count_inc_c,
  output logic             o_term_c
);

  localparam logic [LAT_W-1:0] CNT_MAX = '1;

  logic [LAT_W-1:0] r_count;
  logic [LAT_W-1:0] w_inc;

  assign w_inc = (r_count == CNT_MAX) ? r_count : r_count + LAT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_inc;
    end
  end

  // Compare wide so a TERM beyond the counter range can never match.
  assign o_count_inc_c = w_inc;
  assign o_term_c      = (64'(w_inc) == 64'(TERM));

endmodule

// File: rtl/lenet_run_ctrl.sv
// Run controller: launches the LeNet core, times it, latches the result.
// Optional LENET_HISTORY_EN adds o_history and o_run_count.
module lenet_run_ctrl
  import lenet_pkg::*;
#(
  parameter int unsigned LAT_W   = 20,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_ready,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic               o_go,
  output logic               o_busy,
  output logic               o_result_valid,
  output logic [DIGIT_W-1:0] o_result_digit,
  output logic               o_result_err,
  output logic [LAT_W-1:0]   o_latency
`ifdef LENET_HISTORY_EN
  ,
  output logic [15:0]        o_history,
  output logic [15:0]        o_run_count
`endif
);

  state_t r_state;
  state_t w_next;

  logic               r_ready_q;
  logic               w_ready_rise;
  logic               w_clr;
  logic               w_en;
  logic               w_done;
  logic               w_timeout;
  logic [LAT_W-1:0]   w_inc;
  logic               w_term;
  logic               w_digit_bad;

  logic               r_go;
  logic               r_busy;
  logic               r_result_valid;
  logic [DIGIT_W-1:0] r_result_digit;
  logic               r_result_err;
  logic [LAT_W-1:0]   r_latency;

  assign w_ready_rise = i_ready & ~r_ready_q;
  assign w_digit_bad  = (i_digit > DIGIT_MAX);

  lenet_sat_counter #(
    .LAT_W (LAT_W),
    .TERM  (TIMEOUT)
  ) u_lat_cnt (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (w_clr),
    .i_en          (w_en),
    .o_count_inc_c (w_inc),
    .o_term_c      (w_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Edge on ready wins over a timeout landing in the same RUN cycle.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = ST_GO;
        end
      end
      ST_GO: begin
        w_clr  = 1'b1;
        w_next = ST_RUN;
      end
      ST_RUN: begin
        w_en = 1'b1;
        if (w_ready_rise) begin
          w_done = 1'b1;
          w_next = ST_DONE;
        end else if (w_term) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready_q <= 1'b0;
    end else begin
      r_ready_q <= i_ready;
    end
  end

  // Outputs are registered off the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_go           <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_digit <= '0;
      r_result_err   <= 1'b0;
      r_latency      <= '0;
    end else begin
      r_go           <= (w_next == ST_GO);
      r_busy         <= (w_next == ST_GO) || (w_next == ST_RUN);
      r_result_valid <= w_done;
      if (w_done) begin
        r_result_digit <= i_digit;
        r_latency      <= w_inc;
        r_result_err   <= w_digit_bad;
      end else if (w_timeout) begin
        r_result_err <= 1'b1;
      end
    end
  end

  assign o_go           = r_go;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result_digit = r_result_digit;
  assign o_result_err   = r_result_err;
  assign o_latency      = r_latency;

`ifdef LENET_HISTORY_EN
  logic [15:0] r_history;
  logic [15:0] r_run_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_history   <= '0;
      r_run_count <= '0;
    end else if (w_done && !w_digit_bad) begin
      r_history   <= {r_history[11:0], i_digit};
      r_run_count <= r_run_count + 16'd1;
    end
  end

  assign o_history   = r_history;
  assign o_run_count = r_run_count;
`endif

endmodule
